// File: rtl/expr_pkg.sv
// expr_pkg: shared token encodings, ASCII constants and FSM states for expr_emit
package expr_pkg;
  localparam logic [1:0] TK_DIGIT = 2'b00;
  localparam logic [1:0] TK_PLUS  = 2'b01;
  localparam logic [1:0] TK_MUL   = 2'b10;
  localparam logic [1:0] TK_END   = 2'b11;
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MUL   = 8'h2A;
  typedef enum logic [2:0] {IDLE, START, EXP_D, EXP_O, ERR} state_t;
endpackage

// File: rtl/expr_tok_check.sv
// expr_tok_check: grammar check for one accepted token
// Ports: i_state/i_kind/i_val/i_len in; o_next next state, o_emit/o_char char to send,
// o_is_err error flag (for an end token: the err value to report at done).
module expr_tok_check
  import expr_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5
) (
  input  state_t             i_state,
  input  logic [1:0]         i_kind,
  input  logic [3:0]         i_val,
  input  logic [LEN_W-1:0]   i_len,
  output state_t             o_next,
  output logic               o_emit,
  output logic [7:0]         o_char,
  output logic               o_is_err
);
  logic w_full;
  assign w_full = i_len >= LEN_W'(MAX_LEN);
  always_comb begin
    o_next   = i_state;
    o_emit   = 1'b0;
    o_char   = 8'h00;
    o_is_err = 1'b0;
    if (i_kind == TK_END) begin
      o_next   = IDLE;
      o_is_err = i_state != EXP_O;
    end else if (i_state == EXP_D && i_kind == TK_DIGIT && i_val <= 4'd9 && !w_full) begin
      o_next = EXP_O;
      o_emit = 1'b1;
      o_char = CH_0 + {4'h0, i_val};
    end else if (i_state == EXP_O && i_kind != TK_DIGIT && !w_full) begin
      o_next = EXP_D;
      o_emit = 1'b1;
      o_char = i_kind == TK_PLUS ? CH_PLUS : CH_MUL;
    end else begin
      o_next   = ERR;
      o_is_err = 1'b1;
    end
  end
endmodule

// File: rtl/expr_emit.sv
// expr_emit: token-to-ASCII transmitter feeding the expr recognizer
// Ports: clk, clr (async active-low reset); tok_valid/tok_ready/tok_kind/tok_val token in;
// out/out_valid char out, frame_clr pre-expression clear, done/err status, len chars emitted.
module expr_emit
  import expr_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             tok_valid,
  output logic             tok_ready,
  input  logic [1:0]       tok_kind,
  input  logic [3:0]       tok_val,
  output logic [7:0]       out,
  output logic             out_valid,
  output logic             frame_clr,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] len
);
  state_t           r_state;
  logic [7:0]       r_out;
  logic             r_out_valid, r_frame_clr, r_done, r_err;
  logic [LEN_W-1:0] r_len;
  state_t           w_next;
  logic             w_emit, w_is_err, w_xfer, w_end;
  logic [7:0]       w_char;
  expr_tok_check #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_chk (
    .i_state(r_state), .i_kind(tok_kind), .i_val(tok_val), .i_len(r_len),
    .o_next(w_next), .o_emit(w_emit), .o_char(w_char), .o_is_err(w_is_err)
  );
  assign tok_ready = r_state == EXP_D || r_state == EXP_O || r_state == ERR;
  assign w_xfer    = tok_valid && tok_ready;
  assign w_end     = w_xfer && tok_kind == TK_END;
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state     <= IDLE;
      r_out       <= 8'h00;
      r_out_valid <= 1'b0;
      r_frame_clr <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_len       <= '0;
    end else begin
      r_out_valid <= w_xfer && w_emit;
      r_out       <= (w_xfer && w_emit) ? w_char : 8'h00;
      r_done      <= w_end;
      r_frame_clr <= r_state == IDLE && tok_valid;
      r_err       <= r_state == START ? 1'b0 : w_end ? w_is_err : r_err;
      r_len       <= r_state == START ? '0 : (w_xfer && w_emit) ? r_len + LEN_W'(1) : r_len;
      r_state     <= r_state == IDLE ? (tok_valid ? START : IDLE) :
                     r_state == START ? EXP_D : w_xfer ? w_next : r_state;
    end
  end
  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign frame_clr = r_frame_clr;
  assign done      = r_done;
  assign err       = r_err;
  assign len       = r_len;
endmodule

// File: tb/tb_expr_emit.sv
// tb_expr_emit: scoreboard bench for expr_emit with directed token sequences
module tb_expr_emit;
  import expr_pkg::*;
  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       tok_valid = 1'b0;
  logic       tok_ready;
  logic [1:0] tok_kind = 2'b00;
  logic [3:0] tok_val = 4'h0;
  logic [7:0] out;
  logic       out_valid, frame_clr, done, err;
  logic [4:0] len;
  typedef struct {bit d; logic [7:0] ch; logic e; logic [4:0] l;} exp_t;
  exp_t q[$];
  int n_pass = 0, n_total = 0, n_fclr = 0, n_expr = 0;
  expr_emit #(.MAX_LEN(16), .LEN_W(5)) dut (
    .clk(clk), .clr(clr), .tok_valid(tok_valid), .tok_ready(tok_ready),
    .tok_kind(tok_kind), .tok_val(tok_val), .out(out), .out_valid(out_valid),
    .frame_clr(frame_clr), .done(done), .err(err), .len(len)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic exp_ch(input logic [7:0] c);
    q.push_back('{d: 1'b0, ch: c, e: 1'b0, l: 5'd0});
  endtask
  task automatic exp_done(input logic e, input logic [4:0] l);
    q.push_back('{d: 1'b1, ch: 8'h00, e: e, l: l});
  endtask
  task automatic send(input logic [1:0] k, input logic [3:0] v);
    int n;
    tok_valid = 1'b1;
    tok_kind  = k;
    tok_val   = v;
    n = 0;
    while (!tok_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      n_total++;
      $display("FAIL send_timeout: tok_ready stuck low for kind %0d", k);
    end
    @(negedge clk);
  endtask
  task automatic idle_tok();
    tok_valid = 1'b0;
    tok_kind  = 2'b00;
    tok_val   = 4'h0;
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_total++;
      $display("FAIL drain_timeout: %0d expected events outstanding", q.size());
      q.delete();
    end
    @(negedge clk);
    n_expr++;
    chk("frame_clr_cycles", n_fclr, n_expr);
  endtask
  always @(negedge clk) begin
    if (clr) begin
      exp_t e;
      if (frame_clr) n_fclr++;
      if (out_valid) begin
        if (q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_char: got %0h expected nothing", out);
        end else begin
          e = q.pop_front();
          chk("event_is_char", 32'(!e.d), 32'd1);
          chk("char", out, e.ch);
        end
      end
      if (done) begin
        if (q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_done: got done err=%0d len=%0d expected nothing", err, len);
        end else begin
          e = q.pop_front();
          chk("event_is_done", 32'(e.d), 32'd1);
          chk("done_err", err, e.e);
          chk("done_len", len, e.l);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    #12;
    chk("rst_out", out, 8'h00);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_frame_clr", frame_clr, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_len", len, 5'd0);
    chk("rst_tok_ready", tok_ready, 1'b0);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    chk("idle_tok_ready", tok_ready, 1'b0);
    // "1+2*5"
    exp_ch(8'h31); exp_ch(8'h2B); exp_ch(8'h32); exp_ch(8'h2A); exp_ch(8'h35); exp_done(1'b0, 5'd5);
    send(TK_DIGIT, 4'd1); send(TK_PLUS, 4'd0); send(TK_DIGIT, 4'd2);
    send(TK_MUL, 4'd0); send(TK_DIGIT, 4'd5); send(TK_END, 4'd0);
    idle_tok(); drain();
    // "1+2 3*5": truncated after "1+2"
    exp_ch(8'h31); exp_ch(8'h2B); exp_ch(8'h32); exp_done(1'b1, 5'd3);
    send(TK_DIGIT, 4'd1); send(TK_PLUS, 4'd0); send(TK_DIGIT, 4'd2); send(TK_DIGIT, 4'd3);
    send(TK_MUL, 4'd0); send(TK_DIGIT, 4'd5); send(TK_END, 4'd0);
    idle_tok(); drain();
    // leading operator
    exp_done(1'b1, 5'd0);
    send(TK_PLUS, 4'd0); send(TK_DIGIT, 4'd1); send(TK_END, 4'd0);
    idle_tok(); drain();
    // end only
    exp_done(1'b1, 5'd0);
    send(TK_END, 4'd0);
    idle_tok(); drain();
    // bad digit value
    exp_done(1'b1, 5'd0);
    send(TK_DIGIT, 4'd12); send(TK_END, 4'd0);
    idle_tok(); drain();
    // 17 alternating tokens: 16 chars then overflow
    for (int i = 0; i < 16; i++) exp_ch(i % 2 == 0 ? 8'h31 : 8'h2B);
    exp_done(1'b1, 5'd16);
    for (int i = 0; i < 17; i++) send(i % 2 == 0 ? TK_DIGIT : TK_PLUS, 4'd1);
    send(TK_END, 4'd0);
    idle_tok(); drain();
    // async reset after two chars
    exp_ch(8'h31); exp_ch(8'h2B);
    send(TK_DIGIT, 4'd1); send(TK_PLUS, 4'd0);
    idle_tok();
    @(negedge clk);
    chk("pre_rst_len", len, 5'd2);
    chk("pre_rst_q_empty", q.size(), 0);
    #2 clr = 1'b0;
    #1;
    chk("mid_rst_out", out, 8'h00);
    chk("mid_rst_len", len, 5'd0);
    chk("mid_rst_tok_ready", tok_ready, 1'b0);
    chk("mid_rst_frame_clr", frame_clr, 1'b0);
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    n_expr++;
    // after release: "9"
    exp_ch(8'h39); exp_done(1'b0, 5'd1);
    send(TK_DIGIT, 4'd9); send(TK_END, 4'd0);
    idle_tok(); drain();
    chk("final_q_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/expr_emit.md
Name: expr_emit

Overview:
- Token-to-ASCII transmitter that produces the character stream consumed by the `expr` recognizer.
- Accepts abstract tokens (digit, `+`, `*`, end) over a valid/ready handshake.
- Enforces the recognizer's grammar: digit (op digit)* end.
- Emits one ASCII char per accepted token, plus a per-expression clear pulse and done/error status.
- Sits between test/stimulus logic or a host FSM and `expr`'s `in`/`clr` inputs.

Parameters:
- MAX_LEN, 16, maximum chars per expression; accepting a token beyond this is an error.
- LEN_W, 5, width of the length counter; must hold MAX_LEN.

Ports:
- clk  in  1  system clock, rising edge
- clr  in  1  reset: asynchronous, active-low
- tok_valid  in  1  token present
- tok_ready  out  1  emitter can accept a token
- tok_kind  in  2  2'b00 digit, 2'b01 plus, 2'b10 mul, 2'b11 end
- tok_val  in  4  digit value (digit kind only; ignored otherwise)
- out  out  8  ASCII char for the recognizer
- out_valid  out  1  `out` carries a new char this cycle
- frame_clr  out  1  one-cycle clear pulse to the recognizer before the first char
- done  out  1  one-cycle pulse: expression finished
- err  out  1  expression violated grammar; valid from `done` until next START
- len  out  LEN_W  chars emitted in current expression

Behaviour:
- Reset (clr=0, async):
  - state=IDLE.
  - out=8'h00, out_valid=0, frame_clr=0, done=0, err=0, len=0.
  - Reset mid-expression aborts silently: no done, and no further chars.
- Handshake:
  - A token transfers when tok_valid && tok_ready.
  - tok_ready=1 only in EXP_D, EXP_O and ERR.
  - tok_ready is Moore, from state only.
- States:
  - IDLE: tok_ready=0. If tok_valid, go to START; the token is not consumed.
  - START: frame_clr=1 for exactly this cycle, len<=0, err<=0. Go to EXP_D.
  - EXP_D (expect digit):
    - Digit with val<=9 → emit `"0"+val`, go to EXP_O.
    - Digit with val>9, plus, mul or end → ERR, with one exception: an end token taken here goes straight to IDLE with done=1, err=1.
  - EXP_O (expect operator):
    - Plus → emit 8'h2B; mul → emit 8'h2A; go to EXP_D.
    - Digit → ERR.
    - End → IDLE, done=1, err=0.
  - ERR: accept and drop tokens, nothing emitted. End token → IDLE, done=1, err=1.
- Emission timing:
  - Token accepted in cycle t → out/out_valid registered, visible in cycle t+1 only.
  - Back-to-back tokens give one char per cycle with no bubbles.
  - When out_valid=0, out holds 8'h00; the sink must qualify with out_valid.
- Length rules:
  - len increments on every emitted char.
  - An emitting token while len==MAX_LEN → ERR, no char, len saturates.
- done and err:
  - done is registered: asserted in the cycle after the end token transfers.
  - err is updated in that same cycle and held until the next START.
  - The end token itself never produces a char.
- Illegal tokens are consumed (ready was high); the char stream is truncated at the last legal char.
- Simultaneous events: tok_valid while done is pulsing is legal. State is already IDLE, so START follows next cycle.

Decomposition:
- Package `expr_pkg`:
  - Token kind encodings: TK_DIGIT, TK_PLUS, TK_MUL, TK_END.
  - ASCII constants: CH_0=8'h30, CH_PLUS=8'h2B, CH_MUL=8'h2A.
  - State enum: IDLE, START, EXP_D, EXP_O, ERR.
- Optional sub-module `expr_tok_check` (combinational): inputs state, tok_kind, tok_val, len; outputs next_state, emit, char, is_err.
- Main module holds the state register, output registers and len counter.

Test Plan:
- Legal expression "1+2*5":
  - Tokens presented back-to-back from IDLE → frame_clr pulses 1 cycle.
  - out = 31,2B,32,2A,35 (hex) on 5 consecutive out_valid cycles.
  - done 1 cycle later with err=0, len=5.
- Digit-digit "1+2 3*5":
  - out shows 31,2B,32 only; remaining tokens consumed with tok_ready=1.
  - After end: done=1, err=1, len=3.
- Leading operator / empty expression:
  - `+` first → no chars, done with err=1 after end.
  - End-only token → done=1, err=1, len=0.
- Bad digit value:
  - digit val=12 as first token → no char; err=1 at done.
  - val=9 → out=8'h39.
- Length overflow, MAX_LEN=16:
  - 17 alternating tokens → exactly 16 chars, len=16, err=1 at done.
- Async reset mid-expression:
  - clr=0 after 2 chars → all outputs zero immediately, no done.
  - After release, a new expression starts with frame_clr and len=0.
